// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge
//   Turns the multicycle CPU's level-held Rd/Wr memory requests into a
//   req/ack transaction on a word-wide, variable-latency memory bus. While
//   the transaction is in flight, Stall holds the control unit in its current
//   state. Misaligned addresses and bus timeouts are reported as sticky
//   errors, and both still finish with a Done pulse.
//
// Ports
//   Clk, Reset     rising-edge clock, asynchronous active-low reset
//   Address        CPU byte address (must be word aligned)
//   Rd, Wr         CPU read / write requests, held until Done (Wr wins if both)
//   Datain         CPU write data
//   Dataout        last read data (registered)
//   Stall          CPU hold request
//   Done           one-cycle completion pulse (normal or error completion)
//   Err_align      sticky misaligned-access flag
//   Err_timeout    sticky bus-timeout flag
//   Err_clr        synchronous clear of both sticky flags
//   Mem_req/we     bus request and write enable
//   Mem_addr       latched word address (Address[31:2])
//   Mem_wdata      latched write data
//   Mem_rdata/ack  bus read data and one-cycle completion
module mem_wait_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Stall,
  output logic        Done,
  output logic        Err_align,
  output logic        Err_timeout,
  input  logic        Err_clr,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic [29:0] Mem_addr,
  output logic [31:0] Mem_wdata,
  input  logic [31:0] Mem_rdata,
  input  logic        Mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter value in the last ACCESS cycle allowed before the access aborts.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  // Re-arms only after the CPU has dropped both requests, so a request still
  // held after Done cannot start a second access.
  logic        armed;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      armed       <= 1'b1;
      Dataout     <= '0;
      Done        <= 1'b0;
      Err_align   <= 1'b0;
      Err_timeout <= 1'b0;
      Mem_req     <= 1'b0;
      Mem_we      <= 1'b0;
      Mem_addr    <= '0;
      Mem_wdata   <= '0;
    end else begin
      Done <= 1'b0;
      if (!Rd && !Wr) armed <= 1'b1;
      // Error sets below come later in this block, so a new error wins over
      // a clear in the same cycle.
      if (Err_clr) begin
        Err_align   <= 1'b0;
        Err_timeout <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (armed && (Rd || Wr)) begin
            Mem_addr  <= Address[31:2];
            Mem_wdata <= Datain;
            cnt       <= '0;
            if (Address[1:0] != 2'b00) begin
              Err_align <= 1'b1;
              state     <= DONE;
              Done      <= 1'b1;
              armed     <= 1'b0;
            end else begin
              state   <= ACCESS;
              Mem_req <= 1'b1;
              Mem_we  <= Wr;
            end
          end
        end

        ACCESS: begin
          // Ack is checked first so an ack in the final allowed cycle is a
          // normal completion rather than a timeout.
          if (Mem_ack) begin
            if (!Mem_we) Dataout <= Mem_rdata;
            state   <= DONE;
            Done    <= 1'b1;
            Mem_req <= 1'b0;
            Mem_we  <= 1'b0;
            armed   <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            if (!Mem_we) Dataout <= ERR_DATA;
            Err_timeout <= 1'b1;
            state       <= DONE;
            Done        <= 1'b1;
            Mem_req     <= 1'b0;
            Mem_we      <= 1'b0;
            armed       <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the CPU stalls in the very cycle it raises a request.
  // Gated by Reset so the stall drops as soon as reset is asserted.
  assign Stall = Reset &&
                 (((state == IDLE) && armed && (Rd || Wr)) || (state == ACCESS));

endmodule

// File: tb/tb_mem_wait_bridge.sv
module tb_mem_wait_bridge;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Address = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [31:0] Datain = '0;
  logic [31:0] Dataout;
  logic        Stall;
  logic        Done;
  logic        Err_align;
  logic        Err_timeout;
  logic        Err_clr = 1'b0;
  logic        Mem_req;
  logic        Mem_we;
  logic [29:0] Mem_addr;
  logic [31:0] Mem_wdata;
  logic [31:0] Mem_rdata = '0;
  logic        Mem_ack = 1'b0;

  mem_wait_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Rd(Rd), .Wr(Wr),
    .Datain(Datain), .Dataout(Dataout), .Stall(Stall), .Done(Done),
    .Err_align(Err_align), .Err_timeout(Err_timeout), .Err_clr(Err_clr),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr),
    .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] dout;
    logic        align;
    logic        tmo;
    int          req_cyc;
    int          stall_cyc;
  } exp_t;

  exp_t sb[$];

  // Reference state of the bridge's visible registers.
  logic [31:0] m_dout  = '0;
  logic        m_align = 1'b0;
  logic        m_tmo   = 1'b0;

  // Bus responder configuration, written only by the driver.
  logic [29:0] bus_addr  = '0;
  logic        bus_we    = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata = '0;
  int          bus_waits = 0;   // -1: never acknowledge
  int          bcnt      = 0;

  // Bus model: acks after bus_waits wait cycles, checks the request is stable.
  always @(negedge Clk) begin
    if (Mem_req) begin
      chk("bus_addr", 32'(Mem_addr), 32'(bus_addr));
      chk("bus_we", 32'(Mem_we), 32'(bus_we));
      if (bus_we) chk("bus_wdata", Mem_wdata, bus_wdata);
      Mem_ack   = (bus_waits >= 0) && (bcnt == bus_waits);
      Mem_rdata = bus_rdata;
      bcnt++;
    end else begin
      Mem_ack   = 1'b0;
      Mem_rdata = '0;
      bcnt      = 0;
    end
  end

  // Monitor: counts stall/request cycles and scores each Done.
  int stall_n = 0;
  int req_n   = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      stall_n = 0;
      req_n   = 0;
    end else begin
      if (Stall)   stall_n++;
      if (Mem_req) req_n++;
      if (Done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("dataout", Dataout, e.dout);
          chk("err_align", 32'(Err_align), 32'(e.align));
          chk("err_timeout", 32'(Err_timeout), 32'(e.tmo));
          chk("req_cycles", 32'(req_n), 32'(e.req_cyc));
          chk("stall_cycles", 32'(stall_n), 32'(e.stall_cyc));
        end
        stall_n = 0;
        req_n   = 0;
      end
    end
  end

  // One CPU access; hold = cycles the request stays high after Done.
  task automatic run(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input int waits, input logic [31:0] rdat, input int hold);
    exp_t e;
    int   n;
    bus_addr  = addr[31:2];
    bus_we    = wr;
    bus_wdata = wd;
    bus_waits = waits;
    bus_rdata = rdat;
    if (addr[1:0] != 2'b00) begin
      m_align     = 1'b1;
      e.req_cyc   = 0;
      e.stall_cyc = 1;
    end else if (waits >= 0 && waits < TMO) begin
      if (!wr) m_dout = rdat;
      e.req_cyc   = waits + 1;
      e.stall_cyc = waits + 2;
    end else begin
      m_tmo = 1'b1;
      if (!wr) m_dout = ERR;
      e.req_cyc   = TMO;
      e.stall_cyc = TMO + 1;
    end
    e.dout  = m_dout;
    e.align = m_align;
    e.tmo   = m_tmo;
    sb.push_back(e);

    @(posedge Clk); #1;
    Address = addr;
    Datain  = wd;
    Rd      = !wr;
    Wr      = wr;
    n = 0;
    forever begin
      @(negedge Clk);
      if (Done) break;
      // Scramble the CPU buses mid-access; the latched bus side must not move.
      if (Mem_req) begin
        Address = $urandom;
        Datain  = $urandom;
      end
      n++;
      if (n > 50) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    repeat (hold) begin
      @(negedge Clk);
      chk("held_req", 32'(Mem_req), 32'd0);
      chk("held_stall", 32'(Stall), 32'd0);
      chk("held_done", 32'(Done), 32'd0);
    end
    @(posedge Clk); #1;
    Rd = 1'b0;
    Wr = 1'b0;
  endtask

  task automatic clear_errors();
    @(posedge Clk); #1;
    Err_clr = 1'b1;
    @(posedge Clk); #1;
    Err_clr = 1'b0;
    m_align = 1'b0;
    m_tmo   = 1'b0;
    chk("clr_align", 32'(Err_align), 32'd0);
    chk("clr_timeout", 32'(Err_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req", 32'(Mem_req), 32'd0);
    chk("rst_we", 32'(Mem_we), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_align", 32'(Err_align), 32'd0);
    chk("rst_timeout", 32'(Err_timeout), 32'd0);
    chk("rst_dataout", Dataout, 32'd0);
    chk("rst_addr", 32'(Mem_addr), 32'd0);
    chk("rst_wdata", Mem_wdata, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);

    // Aligned read, zero wait
    run(32'h0000_0010, 1'b0, 32'h0, 0, 32'h1234_5678, 0);
    // Write with 3 wait states, Dataout must not change
    run(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 3, 32'h0BAD_0BAD, 0);
    // Held request must not re-trigger; next access after a drop is normal
    run(32'h0000_0030, 1'b0, 32'h0, 1, 32'hA5A5_5A5A, 5);
    run(32'h0000_0034, 1'b0, 32'h0, 2, 32'h0F0F_1234, 0);
    // Misaligned read: no bus cycle, sticky flag, then clear
    run(32'h0000_0013, 1'b0, 32'h0, 0, 32'h1111_1111, 0);
    chk("align_sticky", 32'(Err_align), 32'd1);
    clear_errors();
    // Read timeout
    run(32'h0000_0040, 1'b0, 32'h0, -1, 32'h2222_2222, 0);
    chk("tmo_sticky", 32'(Err_timeout), 32'd1);
    clear_errors();
    // Ack in the last allowed cycle: no error
    run(32'h0000_0044, 1'b0, 32'h0, TMO - 1, 32'h7777_8888, 0);
    // Write timeout keeps Dataout
    run(32'h0000_0048, 1'b1, 32'h5555_AAAA, -1, 32'h0, 0);
    clear_errors();

    // Asynchronous reset in the middle of an access
    bus_waits = -1;
    bus_addr  = 30'h14;
    bus_we    = 1'b0;
    @(posedge Clk); #1;
    Address = 32'h0000_0050;
    Rd      = 1'b1;
    repeat (3) @(negedge Clk);
    chk("pre_rst_req", 32'(Mem_req), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_req", 32'(Mem_req), 32'd0);
    chk("async_stall", 32'(Stall), 32'd0);
    chk("async_done", 32'(Done), 32'd0);
    Rd = 1'b0;
    @(negedge Clk);
    @(posedge Clk); #1;
    Reset  = 1'b1;
    m_dout = '0;
    m_align = 1'b0;
    m_tmo   = 1'b0;
    run(32'h0000_0060, 1'b0, 32'h0, 1, 32'h9999_0001, 0);

    repeat (3) @(posedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
